icache_assoc_sram: RTL and testbench

ICACHE_ASSOC_SRAM -- requirements
Module: icache_assoc_sram

---
 rtl/icache_pkg.sv | 21 ++
 rtl/icache_way_ram.sv | 52 +++++
 rtl/icache_assoc_sram.sv | 199 +++++++++++++++++++
 tb/tb_icache_assoc_sram.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared types and default parameter values for the
// set-associative instruction cache (FSM state enum, default geometry).
package icache_pkg;

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,   // sweeping sets, clearing valid bits and pointers
      ST_READY = 1'b1    // accepting lookups and fills
   } state_t;

   localparam int DEF_WAYS        = 2;
   localparam int DEF_SETS        = 16;
   localparam int DEF_BLOCK_WORDS = 4;
   localparam int DEF_WORD_W      = 32;
   localparam int DEF_TAG_W       = 24;

   // Width of a way number; a direct-mapped cache still carries one bit.
   function automatic int way_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/icache_way_ram.sv
// icache_way_ram: storage for one cache way. Holds the valid bits, tags
// and data blocks of every set. Two combinational read ports (one for
// lookups, one for the fill-side victim search), one clocked write port
// and a clocked valid-clear port used by the initialisation sweep.
module icache_way_ram #(
   parameter int SETS        = 16,
   parameter int BLOCK_WORDS = 4,
   parameter int WORD_W      = 32,
   parameter int TAG_W       = 24
) (
   input  logic                                 clk,
   input  logic [$clog2(SETS)-1:0]              lk_index,
   output logic                                 lk_valid,
   output logic [TAG_W-1:0]                     lk_tag,
   output logic [BLOCK_WORDS-1:0][WORD_W-1:0]   lk_data,
   input  logic [$clog2(SETS)-1:0]              fill_index,
   output logic                                 fl_valid,
   output logic [TAG_W-1:0]                     fl_tag,
   input  logic                                 wr_en,
   input  logic [TAG_W-1:0]                     wr_tag,
   input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]   wr_data,
   input  logic                                 clr_en,
   input  logic [$clog2(SETS)-1:0]              clr_index
);

   logic [SETS-1:0]                       valid_reg;
   logic [TAG_W-1:0]                      tag_mem  [SETS];
   logic [BLOCK_WORDS-1:0][WORD_W-1:0]    data_mem [SETS];

   assign lk_valid = valid_reg[lk_index];
   assign lk_tag   = tag_mem[lk_index];
   assign lk_data  = data_mem[lk_index];
   assign fl_valid = valid_reg[fill_index];
   assign fl_tag   = tag_mem[fill_index];

   // Valid bits: the sweep clears them, fills set them (never both at once).
   always_ff @(posedge clk) begin
      if (clr_en)
         valid_reg[clr_index] <= 1'b0;
      else if (wr_en)
         valid_reg[fill_index] <= 1'b1;
   end

   // Tag and data arrays are written by fills only; contents are don't-care until valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[fill_index]  <= wr_tag;
         data_mem[fill_index] <= wr_data;
      end
   end

endmodule

// File: rtl/icache_assoc_sram.sv
// icache_assoc_sram: WAYS-way set-associative instruction cache array.
// After reset an INIT sweep clears one set per cycle; in READY, lookups
// return a registered hit/way/block one cycle later and fills write one
// way chosen by matching tag, lowest invalid way, or a per-set pointer.
// Optional macro ICACHE_FLUSH_EN adds a flush input that re-runs the sweep.
module icache_assoc_sram
   import icache_pkg::*;
#(
   parameter int WAYS        = DEF_WAYS,
   parameter int SETS        = DEF_SETS,
   parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
   parameter int WORD_W      = DEF_WORD_W,
   parameter int TAG_W       = DEF_TAG_W
) (
   input  logic                                 clk,
   input  logic                                 rst,
`ifdef ICACHE_FLUSH_EN
   input  logic                                 flush,
`endif
   output logic                                 ready,
   input  logic                                 lookup_valid,
   input  logic [$clog2(SETS)-1:0]              lookup_index,
   input  logic [TAG_W-1:0]                     lookup_tag,
   input  logic                                 fill_valid,
   input  logic [$clog2(SETS)-1:0]              fill_index,
   input  logic [TAG_W-1:0]                     fill_tag,
   input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]   fill_data,
   output logic                                 rd_valid,
   output logic                                 hit,
   output logic [way_bits(WAYS)-1:0]            hit_way,
   output logic [BLOCK_WORDS-1:0][WORD_W-1:0]   hit_data
);

   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = way_bits(WAYS);

   typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0] block_t;

   state_t              state_reg, state_next;
   logic [IDX_W-1:0]    set_cnt_reg, set_cnt_next;
   logic                flush_req;
   logic                lookup_acc;
   logic                fill_we;
   logic                sweep_clr;

   // Per-way read results
   logic [WAYS-1:0]     lk_valid;
   logic [WAYS-1:0]     fl_valid;
   logic [TAG_W-1:0]    lk_tag [WAYS];
   logic [TAG_W-1:0]    fl_tag [WAYS];
   block_t              lk_data [WAYS];
   logic [WAYS-1:0]     way_we;

   // Lookup match and victim choice
   logic                lk_hit;
   logic [WAY_W-1:0]    lk_way;
   block_t              lk_blk;
   logic [WAY_W-1:0]    victim;
   logic                use_ptr;
   logic                found;
   logic [WAY_W-1:0]    ptr_mem [SETS];
   logic [WAY_W-1:0]    ptr_cur;
   logic [WAY_W-1:0]    ptr_next;

`ifdef ICACHE_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   assign ready      = (state_reg == ST_READY);
   // flush wins over a same-cycle request; a fill under reset is dropped
   assign lookup_acc = ready & lookup_valid & ~flush_req;
   assign fill_we    = ready & fill_valid & ~flush_req & ~rst;
   assign sweep_clr  = (state_reg == ST_INIT) & ~rst;

   // State and sweep-counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_INIT;
         set_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         set_cnt_reg <= set_cnt_next;
      end
   end

   // Next state: sweep every set once, then serve; flush restarts the sweep.
   always_comb begin
      state_next   = state_reg;
      set_cnt_next = set_cnt_reg;
      case (state_reg)
         ST_INIT: begin
            set_cnt_next = set_cnt_reg + IDX_W'(1);
            if (set_cnt_reg == IDX_W'(SETS - 1)) begin
               state_next   = ST_READY;
               set_cnt_next = '0;
            end
         end
         ST_READY: begin
            if (flush_req) begin
               state_next   = ST_INIT;
               set_cnt_next = '0;
            end
         end
         default: begin
            state_next   = ST_INIT;
            set_cnt_next = '0;
         end
      endcase
   end

   for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign way_we[gi] = fill_we & (victim == WAY_W'(gi));

      icache_way_ram #(
         .SETS        (SETS),
         .BLOCK_WORDS (BLOCK_WORDS),
         .WORD_W      (WORD_W),
         .TAG_W       (TAG_W)
      ) u_way (
         .clk        (clk),
         .lk_index   (lookup_index),
         .lk_valid   (lk_valid[gi]),
         .lk_tag     (lk_tag[gi]),
         .lk_data    (lk_data[gi]),
         .fill_index (fill_index),
         .fl_valid   (fl_valid[gi]),
         .fl_tag     (fl_tag[gi]),
         .wr_en      (way_we[gi]),
         .wr_tag     (fill_tag),
         .wr_data    (fill_data),
         .clr_en     (sweep_clr),
         .clr_index  (set_cnt_reg)
      );
   end

   // Tag compare across ways; a tag lives in at most one way of a set.
   always_comb begin
      lk_hit = 1'b0;
      lk_way = '0;
      lk_blk = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!lk_hit && lk_valid[w] && (lk_tag[w] == lookup_tag)) begin
            lk_hit = 1'b1;
            lk_way = WAY_W'(w);
            lk_blk = lk_data[w];
         end
      end
   end

   assign ptr_cur  = ptr_mem[fill_index];
   assign ptr_next = (ptr_cur == WAY_W'(WAYS - 1)) ? '0 : ptr_cur + WAY_W'(1);

   // Victim: way already holding the tag, else lowest invalid way, else pointer.
   always_comb begin
      victim  = ptr_cur;
      use_ptr = 1'b1;
      found   = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found && fl_valid[w] && (fl_tag[w] == fill_tag)) begin
            victim  = WAY_W'(w);
            use_ptr = 1'b0;
            found   = 1'b1;
         end
      end
      for (int w = 0; w < WAYS; w++) begin
         if (!found && !fl_valid[w]) begin
            victim  = WAY_W'(w);
            use_ptr = 1'b0;
            found   = 1'b1;
         end
      end
   end

   // Round-robin pointers: cleared by the sweep, advanced only when they chose.
   always_ff @(posedge clk) begin
      if (sweep_clr)
         ptr_mem[set_cnt_reg] <= '0;
      else if (fill_we && use_ptr)
         ptr_mem[fill_index] <= ptr_next;
   end

   // Registered lookup result; zeros on a miss or when nothing was looked up.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         hit      <= 1'b0;
         hit_way  <= '0;
         hit_data <= '0;
      end else begin
         rd_valid <= lookup_acc;
         hit      <= lookup_acc & lk_hit;
         hit_way  <= lookup_acc ? lk_way : '0;
         hit_data <= lookup_acc ? lk_blk : '0;
      end
   end

endmodule

// File: tb/tb_icache_assoc_sram.sv
// tb_icache_assoc_sram: directed vector table plus randomized traffic
// checked against a behavioural model of the cache contents.
// Flush checks are included when ICACHE_FLUSH_EN is defined.
module tb_icache_assoc_sram;

   localparam int WAYS = 2;
   localparam int SETS = 16;
   localparam int BW   = 4;
   localparam int WW   = 32;
   localparam int TW   = 24;

   logic                    clk = 1'b0;
   logic                    rst;
`ifdef ICACHE_FLUSH_EN
   logic                    flush;
`endif
   logic                    ready;
   logic                    lookup_valid;
   logic [3:0]              lookup_index;
   logic [TW-1:0]           lookup_tag;
   logic                    fill_valid;
   logic [3:0]              fill_index;
   logic [TW-1:0]           fill_tag;
   logic [BW-1:0][WW-1:0]   fill_data;
   logic                    rd_valid;
   logic                    hit;
   logic [0:0]              hit_way;
   logic [BW-1:0][WW-1:0]   hit_data;

   int n_checks = 0;
   int n_fail   = 0;
   int n_txn    = 0;

   icache_assoc_sram #(
      .WAYS(WAYS), .SETS(SETS), .BLOCK_WORDS(BW), .WORD_W(WW), .TAG_W(TW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
`ifdef ICACHE_FLUSH_EN
      .flush        (flush),
`endif
      .ready        (ready),
      .lookup_valid (lookup_valid),
      .lookup_index (lookup_index),
      .lookup_tag   (lookup_tag),
      .fill_valid   (fill_valid),
      .fill_index   (fill_index),
      .fill_tag     (fill_tag),
      .fill_data    (fill_data),
      .rd_valid     (rd_valid),
      .hit          (hit),
      .hit_way      (hit_way),
      .hit_data     (hit_data)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural model ----------------
   bit            m_valid [SETS][WAYS];
   logic [TW-1:0] m_tag   [SETS][WAYS];
   logic [127:0]  m_data  [SETS][WAYS];
   int            m_ptr   [SETS];

   function automatic void m_reset();
      for (int s = 0; s < SETS; s++) begin
         m_ptr[s] = 0;
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      end
   endfunction

   function automatic void m_lookup(input int s, input logic [TW-1:0] t,
                                    output bit h, output int w, output logic [127:0] d);
      h = 1'b0; w = 0; d = '0;
      for (int k = 0; k < WAYS; k++)
         if (m_valid[s][k] && m_tag[s][k] == t) begin
            h = 1'b1; w = k; d = m_data[s][k];
         end
   endfunction

   function automatic void m_fill(input int s, input logic [TW-1:0] t, input logic [127:0] d);
      int v = -1;
      for (int k = 0; k < WAYS; k++)
         if (m_valid[s][k] && m_tag[s][k] == t) v = k;
      for (int k = WAYS - 1; k >= 0; k--)
         if (v < 0 || !m_valid[s][v] || m_tag[s][v] != t)
            if (!m_valid[s][k]) v = k;
      if (v < 0) begin
         v = m_ptr[s];
         m_ptr[s] = (m_ptr[s] + 1) % WAYS;
      end
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = t;
      m_data[s][v]  = d;
   endfunction

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] blk(input logic [31:0] s);
      return {s + 32'd3, s + 32'd2, s + 32'd1, s};
   endfunction

   task automatic wait_ready(input string name);
      int n = 0;
      while (!ready && n < 100) begin
         n++;
         tick();
      end
      chk(name, 128'(n), 128'(SETS));
   endtask

   task automatic idle_inputs();
      lookup_valid = 1'b0; lookup_index = '0; lookup_tag = '0;
      fill_valid   = 1'b0; fill_index   = '0; fill_tag   = '0; fill_data = '0;
   endtask

   // One cycle of traffic checked against the model.
   task automatic drive_and_check(input bit lv, input int li, input logic [TW-1:0] lt,
                                  input bit fv, input int fi, input logic [TW-1:0] ft,
                                  input logic [127:0] fd);
      bit eh; int ew; logic [127:0] ed;
      lookup_valid = lv; lookup_index = 4'(li); lookup_tag = lt;
      fill_valid   = fv; fill_index   = 4'(fi); fill_tag   = ft; fill_data = fd;
      m_lookup(li, lt, eh, ew, ed);
      if (fv) m_fill(fi, ft, fd);
      tick();
      idle_inputs();
      n_txn++;
      $display("txn %0d lk=%0b set=%0d tag=%h fill=%0b set=%0d tag=%h -> rdv=%0b hit=%0b way=%0d",
               n_txn, lv, li, lt, fv, fi, ft, rd_valid, hit, hit_way);
      chk("model_rd_valid", 128'(rd_valid), 128'(lv));
      if (lv) begin
         chk("model_hit",      128'(hit),      128'(eh));
         chk("model_hit_way",  128'(hit_way),  128'(ew));
         chk("model_hit_data", 128'(hit_data), ed);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit            lv;
      int            li;
      logic [TW-1:0] lt;
      bit            fv;
      int            fi;
      logic [TW-1:0] ft;
      logic [127:0]  fd;
      bit            e_hit;
      int            e_way;
      logic [127:0]  e_data;
   } vec_t;

   localparam int NV = 19;
   vec_t vt [NV];

   function automatic vec_t mkv(bit lv, int li, logic [TW-1:0] lt, bit fv, int fi,
                                logic [TW-1:0] ft, logic [127:0] fd,
                                bit e_hit, int e_way, logic [127:0] e_data);
      vec_t v;
      v.lv = lv; v.li = li; v.lt = lt; v.fv = fv; v.fi = fi; v.ft = ft; v.fd = fd;
      v.e_hit = e_hit; v.e_way = e_way; v.e_data = e_data;
      return v;
   endfunction

   initial begin
      logic [127:0] d0, d1, d2, d3, d4, d5, d6, d7;
      d0 = blk(32'hA000_0000); d1 = blk(32'h1100_0000); d2 = blk(32'h2200_0000);
      d3 = blk(32'h3300_0000); d4 = blk(32'hC000_0000); d5 = blk(32'hA5A5_0000);
      d6 = blk(32'hE000_0000); d7 = blk(32'hF000_0000);

      //            lv li lt     fv fi ft     fd   hit way data
      vt[0]  = mkv(0, 0, 24'h0, 1, 3, 24'hA, d0, 0, 0, '0);   // fill set 3 tag A
      vt[1]  = mkv(1, 3, 24'hA, 0, 0, 24'h0, '0, 1, 0, d0);   // hit way 0
      vt[2]  = mkv(1, 3, 24'hB, 0, 0, 24'h0, '0, 0, 0, '0);   // miss, zeros
      vt[3]  = mkv(0, 0, 24'h0, 1, 5, 24'h1, d1, 0, 0, '0);   // set 5 tag 1 -> way 0
      vt[4]  = mkv(0, 0, 24'h0, 1, 5, 24'h2, d2, 0, 0, '0);   // tag 2 -> way 1
      vt[5]  = mkv(0, 0, 24'h0, 1, 5, 24'h3, d3, 0, 0, '0);   // tag 3 -> pointer way 0
      vt[6]  = mkv(1, 5, 24'h1, 0, 0, 24'h0, '0, 0, 0, '0);   // tag 1 evicted
      vt[7]  = mkv(1, 5, 24'h2, 0, 0, 24'h0, '0, 1, 1, d2);
      vt[8]  = mkv(1, 5, 24'h3, 0, 0, 24'h0, '0, 1, 0, d3);
      vt[9]  = mkv(1, 7, 24'hC, 1, 7, 24'hC, d4, 0, 0, '0);   // same-cycle: pre-fill view
      vt[10] = mkv(1, 7, 24'hC, 0, 0, 24'h0, '0, 1, 0, d4);
      vt[11] = mkv(0, 0, 24'h0, 1, 3, 24'hA, d5, 0, 0, '0);   // refill tag A
      vt[12] = mkv(1, 3, 24'hA, 0, 0, 24'h0, '0, 1, 0, d5);   // new data, same way
      vt[13] = mkv(0, 0, 24'h0, 1, 3, 24'hE, d6, 0, 0, '0);   // invalid way 1 taken
      vt[14] = mkv(0, 0, 24'h0, 1, 3, 24'hF, d7, 0, 0, '0);   // pointer still 0 -> way 0
      vt[15] = mkv(1, 3, 24'hE, 0, 0, 24'h0, '0, 1, 1, d6);
      vt[16] = mkv(1, 3, 24'hA, 0, 0, 24'h0, '0, 0, 0, '0);
      vt[17] = mkv(1, 3, 24'hF, 0, 0, 24'h0, '0, 1, 0, d7);
      vt[18] = mkv(0, 0, 24'h0, 0, 0, 24'h0, '0, 0, 0, '0);   // idle: no rd_valid

      // ---- reset state ----
      idle_inputs();
      rst = 1'b1;
`ifdef ICACHE_FLUSH_EN
      flush = 1'b0;
`endif
      repeat (3) tick();
      chk("rst_ready",    128'(ready),    128'(0));
      chk("rst_rd_valid", 128'(rd_valid), 128'(0));
      chk("rst_hit",      128'(hit),      128'(0));
      chk("rst_hit_way",  128'(hit_way),  128'(0));
      chk("rst_hit_data", 128'(hit_data), 128'(0));
      rst = 1'b0;
      wait_ready("init_cycles");
      m_reset();

      // ---- directed table ----
      for (int i = 0; i < NV; i++) begin
         lookup_valid = vt[i].lv; lookup_index = 4'(vt[i].li); lookup_tag = vt[i].lt;
         fill_valid   = vt[i].fv; fill_index   = 4'(vt[i].fi); fill_tag   = vt[i].ft;
         fill_data    = vt[i].fd;
         if (vt[i].fv) m_fill(vt[i].fi, vt[i].ft, vt[i].fd);
         tick();
         idle_inputs();
         n_txn++;
         $display("txn %0d vec %0d -> rdv=%0b hit=%0b way=%0d data=%h",
                  n_txn, i, rd_valid, hit, hit_way, hit_data);
         chk($sformatf("vec%0d_rd_valid", i), 128'(rd_valid), 128'(vt[i].lv));
         if (vt[i].lv) begin
            chk($sformatf("vec%0d_hit", i),      128'(hit),      128'(vt[i].e_hit));
            chk($sformatf("vec%0d_hit_way", i),  128'(hit_way),  128'(vt[i].e_way));
            chk($sformatf("vec%0d_hit_data", i), 128'(hit_data), vt[i].e_data);
         end
      end

      // ---- reset during operation drops a same-cycle fill ----
      fill_valid = 1'b1; fill_index = 4'd9; fill_tag = 24'h55; fill_data = blk(32'h5500_0000);
      rst = 1'b1;
      tick();
      idle_inputs();
      rst = 1'b0;
      chk("rst_op_ready",    128'(ready),    128'(0));
      chk("rst_op_rd_valid", 128'(rd_valid), 128'(0));
      // ---- reset mid-sweep restarts from set 0 ----
      repeat (5) tick();
      chk("mid_sweep_ready", 128'(ready), 128'(0));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_ready("resweep_cycles");
      m_reset();
      drive_and_check(1, 9, 24'h55, 0, 0, 24'h0, '0);   // dropped fill: miss
      drive_and_check(1, 5, 24'h2,  0, 0, 24'h0, '0);   // old contents gone
      drive_and_check(1, 3, 24'hF,  0, 0, 24'h0, '0);

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 300; i++) begin
         drive_and_check(bit'($urandom_range(0, 1)), int'($urandom_range(0, SETS - 1)),
                         24'($urandom_range(0, 5)),
                         bit'($urandom_range(0, 1)), int'($urandom_range(0, SETS - 1)),
                         24'($urandom_range(0, 5)),
                         {$urandom, $urandom, $urandom, $urandom});
      end

`ifdef ICACHE_FLUSH_EN
      // ---- flush: fill 4 sets, flush, all miss afterwards ----
      for (int s = 0; s < 4; s++)
         drive_and_check(0, 0, 24'h0, 1, s, 24'h40 + 24'(s), blk(32'(s) << 8));
      flush = 1'b1;
      fill_valid = 1'b1; fill_index = 4'd4; fill_tag = 24'h77; fill_data = blk(32'h7700_0000);
      tick();
      flush = 1'b0;
      idle_inputs();
      chk("flush_ready", 128'(ready), 128'(0));
      wait_ready("flush_cycles");
      m_reset();
      for (int s = 0; s < 4; s++)
         drive_and_check(1, s, 24'h40 + 24'(s), 0, 0, 24'h0, '0);
      drive_and_check(1, 4, 24'h77, 0, 0, 24'h0, '0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
